// File: rtl/ub_read_sequencer_pkg.sv
// Shared types and constants for the unified-buffer read path.
package ub_read_sequencer_pkg;

  localparam int UB_MATRIX_WIDTH = 14;
  localparam int UB_TILE_DEPTH   = 4096;
  localparam int UB_READ_LATENCY = 3;

  typedef logic [7:0]                           byte_type;
  typedef logic [$clog2(UB_TILE_DEPTH)-1:0]     buffer_addr_type;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_ISSUE, SEQ_DRAIN} seq_state_type;

  // Reduce a row index into the buffer's address range.
  function automatic buffer_addr_type addr_wrap(input logic [31:0] a, input int depth);
    return buffer_addr_type'(a % depth);
  endfunction

endpackage

// File: rtl/ub_read_sequencer_skew.sv
// Triangular delay lines: lane i reaches the output i cycles after lane 0.
// Every lane is registered once on entry; data is zeroed on entry when the
// row is not valid, so an invalid lane always reads back as 0.
module systolic_skew
  import ub_read_sequencer_pkg::*;
#(
  parameter int MATRIX_WIDTH = UB_MATRIX_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  byte_type [MATRIX_WIDTH-1:0]   in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output byte_type [MATRIX_WIDTH-1:0]   out_data,
  output logic [MATRIX_WIDTH-1:0]       out_valid,
  output logic                          out_last
);

  for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_lane
    logic     [i:0] v_pipe;
    byte_type [i:0] d_pipe;

    // Lane i: entry register plus i further stages, advancing with enable.
    always_ff @(posedge clk) begin
      if (!rst) begin
        v_pipe <= '0;
        d_pipe <= '0;
      end else if (enable) begin
        v_pipe[0] <= in_valid;
        d_pipe[0] <= in_valid ? in_data[i] : '0;
        for (int s = 1; s <= i; s++) begin
          v_pipe[s] <= v_pipe[s-1];
          d_pipe[s] <= d_pipe[s-1];
        end
      end
    end

    assign out_valid[i] = v_pipe[i];
    assign out_data[i]  = d_pipe[i];
  end

  logic [MATRIX_WIDTH-1:0] l_pipe;

  // Last-row flag rides alongside the deepest lane.
  always_ff @(posedge clk) begin
    if (!rst) begin
      l_pipe <= '0;
    end else if (enable) begin
      l_pipe[0] <= in_valid && in_last;
      for (int s = 1; s < MATRIX_WIDTH; s++) l_pipe[s] <= l_pipe[s-1];
    end
  end

  assign out_last = l_pipe[MATRIX_WIDTH-1];

endmodule

// File: rtl/ub_read_sequencer.sv
// Unified-buffer port-0 read sequencer: issues one row read per enabled
// cycle, tracks the buffer's read latency and skews rows for the MMU.
module ub_read_sequencer
  import ub_read_sequencer_pkg::*;
#(
  parameter int MATRIX_WIDTH = UB_MATRIX_WIDTH,
  parameter int TILE_WIDTH   = UB_TILE_DEPTH,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  buffer_addr_type               cmd_addr,
  input  logic [LEN_WIDTH-1:0]          cmd_length,
  output buffer_addr_type               ub_addr0,
  output logic                          ub_en0,
  input  byte_type [MATRIX_WIDTH-1:0]   ub_read_port0,
  output byte_type [MATRIX_WIDTH-1:0]   out_data,
  output logic [MATRIX_WIDTH-1:0]       out_valid,
  output logic                          out_last,
  output logic                          busy
);

  // Drain long enough for the last row to leave the deepest skew lane.
  localparam int DRAIN_CYC = UB_READ_LATENCY + MATRIX_WIDTH;
  localparam int DCW       = $clog2(DRAIN_CYC + 1);

  seq_state_type                state, state_nxt;
  buffer_addr_type              cur_addr;
  logic [LEN_WIDTH-1:0]         remaining;
  logic [DCW-1:0]               drain_cnt;
  logic                         zero_len;
  logic                         accept;
  logic                         issue;
  logic                         issue_last;
  logic [UB_READ_LATENCY-1:0]   vld_pipe;
  logic [UB_READ_LATENCY-1:0]   last_pipe;

  // Next state and handshake/read-enable outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    ub_en0    = 1'b0;
    busy      = (state != SEQ_IDLE);
    case (state)
      SEQ_IDLE: begin
        // Acceptance ignores enable so a command can land during a stall.
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_length == '0) ? SEQ_DRAIN : SEQ_ISSUE;
      end
      SEQ_ISSUE: begin
        // Reads only on enabled cycles keep the RAM output stable in a stall.
        ub_en0 = enable;
        if (enable && remaining == LEN_WIDTH'(1)) state_nxt = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (enable && (zero_len || drain_cnt == DCW'(DRAIN_CYC - 1))) state_nxt = SEQ_IDLE;
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

  assign accept     = cmd_valid && cmd_ready;
  assign issue      = ub_en0;
  assign issue_last = issue && (remaining == LEN_WIDTH'(1));
  assign ub_addr0   = cur_addr;

  // State register, address/length counters and drain counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SEQ_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      drain_cnt <= '0;
      zero_len  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur_addr  <= addr_wrap(32'(cmd_addr), TILE_WIDTH);
        remaining <= cmd_length;
        zero_len  <= (cmd_length == '0);
        drain_cnt <= '0;
      end else if (enable) begin
        if (issue) begin
          cur_addr  <= addr_wrap(32'(cur_addr) + 32'd1, TILE_WIDTH);
          remaining <= remaining - LEN_WIDTH'(1);
        end
        drain_cnt <= (state == SEQ_DRAIN) ? drain_cnt + DCW'(1) : '0;
      end
    end
  end

  // Valid/last shadow of the buffer's read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (enable) begin
      vld_pipe  <= {vld_pipe[UB_READ_LATENCY-2:0], issue};
      last_pipe <= {last_pipe[UB_READ_LATENCY-2:0], issue_last};
    end
  end

  systolic_skew #(.MATRIX_WIDTH(MATRIX_WIDTH)) u_skew (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_data   (ub_read_port0),
    .in_valid  (vld_pipe[UB_READ_LATENCY-1]),
    .in_last   (last_pipe[UB_READ_LATENCY-1]),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Randomized bench for ub_read_sequencer against a row-level reference model.
module tb_ub_read_sequencer;
  import ub_read_sequencer_pkg::*;

  localparam int MW = 14;
  localparam int TW = 4096;

  typedef byte_type [MW-1:0] row_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            cmd_valid;
  logic            cmd_ready;
  buffer_addr_type cmd_addr;
  logic [15:0]     cmd_length;
  buffer_addr_type ub_addr0;
  logic            ub_en0;
  row_t            ub_read_port0;
  row_t            out_data;
  logic [MW-1:0]   out_valid;
  logic            out_last;
  logic            busy;

  ub_read_sequencer #(.MATRIX_WIDTH(MW), .TILE_WIDTH(TW), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_length(cmd_length),
    .ub_addr0(ub_addr0), .ub_en0(ub_en0), .ub_read_port0(ub_read_port0),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;
  bit stall_force = 0;
  int stall_pct = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rb(input int r, input int i);
    return 8'((16 * r + i) % 256);
  endfunction

  function automatic row_t rowdata(input int r);
    row_t d;
    for (int i = 0; i < MW; i++) d[i] = rb(r, i);
    return d;
  endfunction

  // Buffer model: 3 enabled cycles from read to data on read_port0.
  row_t bp0, bp1, bp2;
  always @(posedge clk) begin
    if (!rst) begin
      bp0 <= '0; bp1 <= '0; bp2 <= '0;
    end else if (enable) begin
      bp0 <= ub_en0 ? rowdata(int'(ub_addr0)) : '0;
      bp1 <= bp0;
      bp2 <= bp1;
    end
  end
  assign ub_read_port0 = bp2;

  // Reference model: rows to issue, enabled-cycle count, issued rows by index.
  int ecount = 0;
  bit m_busy = 0;
  int pend[$];
  int free_at = 0;
  int iss_addr[int];
  bit iss_last[int];

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 0;
      pend.delete();
      iss_addr.delete();
      iss_last.delete();
    end else begin
      if (m_busy && pend.size() > 0 && enable) begin
        iss_addr[ecount] = pend[0];
        iss_last[ecount] = (pend.size() == 1);
        void'(pend.pop_front());
        // Last row leaves lane MW-1 at +4+MW-1; idle the enabled cycle after.
        if (pend.size() == 0) free_at = ecount + 4 + MW;
      end else if (!m_busy && cmd_valid) begin
        m_busy = 1;
        for (int j = 0; j < int'(cmd_length); j++) pend.push_back((int'(cmd_addr) + j) % TW);
        if (cmd_length == 0) free_at = ecount + (enable ? 1 : 0) + 1;
      end
      if (enable) ecount++;
      if (m_busy && pend.size() == 0 && ecount == free_at) m_busy = 0;
    end
  end

  // Compare every DUT output against the model each cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [MW-1:0] ev;
      logic          el;
      bit            een;
      int            k;
      ev = '0;
      el = 1'b0;
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      een = m_busy && pend.size() > 0 && enable;
      chk("ub_en0", 32'(ub_en0), 32'(een));
      if (een) chk("ub_addr0", 32'(ub_addr0), 32'(pend[0]));
      for (int i = 0; i < MW; i++) begin
        k = ecount - 4 - i;
        if (iss_addr.exists(k)) begin
          ev[i] = 1'b1;
          chk("lane_data", 32'(out_data[i]), 32'(rb(iss_addr[k], i)));
          if (i == MW - 1) el = iss_last[k];
        end else begin
          chk("lane_zero", 32'(out_data[i]), 32'd0);
        end
      end
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_last", 32'(out_last), 32'(el));
    end
  end

  // Enable driver: random stalls, or a forced stall window.
  initial begin
    enable = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      enable = stall_force ? 1'b0 : (int'($urandom_range(0, 99)) >= stall_pct);
    end
  end

  // Present a command and hold it until accepted; returns 1ns after the accept edge.
  task automatic send_cmd(input int addr, input int len);
    bit done;
    done = 0;
    cmd_valid  = 1'b1;
    cmd_addr   = buffer_addr_type'(addr);
    cmd_length = 16'(len);
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) done = 1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) chk("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1 && !m_busy) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_length = '0;
    @(posedge clk); #1;
    chk_on = 1;
    @(negedge clk);
    chk("rst_addr", 32'(ub_addr0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1 basic: issue at accept+1, lane0 at +4, lane13 at +17
    send_cmd(2, 3);
    repeat (4) @(posedge clk);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("t1_lane0", 32'(out_data[0]), 32'(8'h20 + 8'(16 * r)));
    end
    repeat (11) @(posedge clk);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("t1_lane13", 32'(out_data[MW-1]), 32'(8'h2D + 8'(16 * r)));
      chk("t1_last", 32'(out_last), 32'(r == 2));
    end
    @(posedge clk); #1;
    wait_idle();

    // 2 stall for 5 cycles after the first issue
    send_cmd(2, 3);
    @(posedge clk); #1;
    stall_force = 1;
    repeat (5) @(posedge clk);
    #1;
    stall_force = 0;
    wait_idle();

    // 3 address wrap
    send_cmd(TW - 2, 4);
    repeat (4) @(posedge clk);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("t3_lane0", 32'(out_data[0]), 32'(rb((TW - 2 + r) % TW, 0)));
    end
    @(posedge clk); #1;
    wait_idle();

    // 4 zero length: ready again two cycles after accept
    send_cmd(7, 0);
    @(negedge clk);
    chk("t4_ready_drain", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_ready_back", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // 5 back-pressure: second command held while the first drains
    send_cmd(10, 2);
    send_cmd(100, 1);
    wait_idle();

    // 6 reset after two issues of eight, then a fresh command
    send_cmd(50, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_en0", 32'(ub_en0), 32'd0);
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    send_cmd(2, 3);
    wait_idle();

    // random commands with random stalls, some back-to-back
    stall_pct = 30;
    for (int n = 0; n < 30; n++) begin
      int a;
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(TW - 6, TW - 1))
                                      : int'($urandom_range(0, TW - 1));
      send_cmd(a, int'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    stall_pct = 0;
    wait_idle();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
